// File: rtl/svm_serial_mac_classifier.sv
// rtl/svm_serial_mac_classifier.sv - linear SVM scorer using one shared multiplier, one feature per cycle
module svm_serial_mac_classifier #(
  parameter int NUM_FEAT  = 11,
  parameter int IN_W      = 4,
  parameter int COEF_W    = 8,
  parameter int ACC_W     = 16,
  parameter int OUT_W     = 14,
  parameter logic [NUM_FEAT*COEF_W-1:0] COEFS = {
    8'sd64, 8'sd36, -8'sd7, -8'sd15, -8'sd23, 8'sd8,
    -8'sd24, 8'sd16, -8'sd4, -8'sd42, 8'sd17},
  parameter int INTERCEPT = 2763,
  parameter bit SAT_EN    = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_FEAT*IN_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_score,
  output logic                     out_class,
  output logic                     busy
);

  localparam int IDX_W  = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam int PROD_W = IN_W + 1 + COEF_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [NUM_FEAT*IN_W-1:0]  r_feat;
  logic signed [ACC_W-1:0]   r_acc;
  logic [IDX_W-1:0]          r_idx;
  logic [OUT_W-1:0]          r_score;
  logic                      r_class;

  logic [IN_W-1:0]           w_feat_arr [NUM_FEAT];
  logic signed [COEF_W-1:0]  w_coef_arr [NUM_FEAT];
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_acc_next;
  logic [OUT_W-1:0]          w_score;
  logic                      w_accept;

  genvar g;
  generate
    for (g = 0; g < NUM_FEAT; g++) begin : g_unpack
      assign w_feat_arr[g] = r_feat[g*IN_W +: IN_W];
      assign w_coef_arr[g] = COEFS[g*COEF_W +: COEF_W];
    end
  endgenerate

  // Feature is zero-extended so it multiplies as a non-negative signed value.
  assign w_prod     = PROD_W'($signed({1'b0, w_feat_arr[r_idx]})) * PROD_W'(w_coef_arr[r_idx]);
  assign w_acc_next = r_acc + ACC_W'(w_prod);

  always_comb begin
    w_score = w_acc_next[OUT_W-1:0];
    if (SAT_EN) begin
      if (w_acc_next > SAT_MAX)
        w_score = SAT_MAX[OUT_W-1:0];
      else if (w_acc_next < SAT_MIN)
        w_score = SAT_MIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          w_state_next = S_ACCUM;
      end
      S_ACCUM: begin
        busy = 1'b1;
        if (r_idx == LAST_IDX)
          w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready)
          w_state_next = in_valid ? S_ACCUM : S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_feat  <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      r_score <= '0;
      r_class <= 1'b0;
    end else if (w_accept) begin
      r_feat <= in_data;
      r_acc  <= ACC_W'(INTERCEPT);
      r_idx  <= '0;
    end else if (r_state == S_ACCUM) begin
      r_acc <= w_acc_next;
      if (r_idx == LAST_IDX) begin
        r_score <= w_score;
        r_class <= ~w_acc_next[ACC_W-1];
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign out_score = r_score;
  assign out_class = r_class;

endmodule
